tqvp_rebeccargb_universal_encoder: RTL and testbench

- TinyQV peripheral that is the inverse of the universal decoder.
- Samples an external 7-segment pattern on ui_in, synchronises and debounces it, and encodes it into a hex/blank/minus code byte.
- Each new stable code is pushed into a small FIFO that the CPU reads over the standard 4-bit peripheral register interface.
- The current code is also echoed on uo_out.

---
 rtl/tqvp_rebeccargb_ubcd_pkg.sv | 87 ++++++++
 rtl/tqvp_rebeccargb_ubce_fifo.sv | 57 +++++
 rtl/tqvp_rebeccargb_universal_encoder.sv | 126 ++++++++++++
 tb/tb_tqvp_rebeccargb_universal_encoder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tqvp_rebeccargb_ubcd_pkg.sv
// Shared constants and the segment-to-code encoder for the universal encoder.
package tqvp_rebeccargb_ubcd_pkg;

  // Register map
  localparam logic [3:0] ADDR_CODE     = 4'h0;
  localparam logic [3:0] ADDR_FIFO     = 4'h1;
  localparam logic [3:0] ADDR_STATUS   = 4'h2;
  localparam logic [3:0] ADDR_DEBOUNCE = 4'h3;

  // STATUS bit positions (bits 3:0 hold the FIFO count)
  localparam int STATUS_OVF_BIT   = 7;
  localparam int STATUS_EMPTY_BIT = 6;
  localparam int STATUS_FULL_BIT  = 5;

  // CODE field positions (bits 3:0 hold the hex value)
  localparam int CODE_VALID_BIT = 7;
  localparam int CODE_BLANK_BIT = 6;
  localparam int CODE_MINUS_BIT = 5;
  localparam int CODE_DP_BIT    = 4;

  localparam logic [7:0] CODE_RESET     = 8'hC0;
  localparam logic [7:0] DEBOUNCE_RESET = 8'h0F;

  // Segment patterns, bit0..6 = a..g
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_7_ALT = 7'h27;
  localparam logic [6:0] SEG_9_ALT = 7'h67;

  // Map a 7-segment pattern plus decimal point to a CODE byte.
  function automatic logic [7:0] encode_segments(input logic [6:0] seg, input logic dp);
    logic [7:0] code;
    logic       hit;
    logic [3:0] hex;
    code = '0;
    hit  = 1'b1;
    hex  = 4'h0;
    case (seg)
      SEG_0:            hex = 4'h0;
      SEG_1:            hex = 4'h1;
      SEG_2:            hex = 4'h2;
      SEG_3:            hex = 4'h3;
      SEG_4:            hex = 4'h4;
      SEG_5:            hex = 4'h5;
      SEG_6:            hex = 4'h6;
      SEG_7, SEG_7_ALT: hex = 4'h7;
      SEG_8:            hex = 4'h8;
      SEG_9, SEG_9_ALT: hex = 4'h9;
      SEG_A:            hex = 4'hA;
      SEG_B:            hex = 4'hB;
      SEG_C:            hex = 4'hC;
      SEG_D:            hex = 4'hD;
      SEG_E:            hex = 4'hE;
      SEG_F:            hex = 4'hF;
      default:          hit = 1'b0;
    endcase
    if (seg == SEG_BLANK) begin
      code[CODE_VALID_BIT] = 1'b1;
      code[CODE_BLANK_BIT] = 1'b1;
    end else if (seg == SEG_MINUS) begin
      code[CODE_VALID_BIT] = 1'b1;
      code[CODE_MINUS_BIT] = 1'b1;
    end else if (hit) begin
      code[CODE_VALID_BIT] = 1'b1;
      code[3:0]            = hex;
    end
    code[CODE_DP_BIT] = dp;
    return code;
  endfunction

endpackage

// File: rtl/tqvp_rebeccargb_ubce_fifo.sv
// Small code FIFO; a push into a full FIFO succeeds when a pop happens the same cycle.
module tqvp_rebeccargb_ubce_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       full,
  output logic       empty,
  output logic [3:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == 4'(DEPTH));
  assign empty   = (count == 4'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? 8'h00 : mem[rd_ptr];

  // Storage; only accepted pushes land, flush blocks the write.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 4'd0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 4'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tqvp_rebeccargb_universal_encoder.sv
// TinyQV peripheral: debounces a 7-segment pattern on ui_in, encodes it, and queues each new code.
module tqvp_rebeccargb_universal_encoder
  import tqvp_rebeccargb_ubcd_pkg::*;
#(
  parameter int PRESCALE_BITS = 6,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  logic [7:0]               sync1;
  logic [7:0]               sync2;
  logic [7:0]               cand;
  logic [7:0]               craw;
  logic [7:0]               code;
  logic [7:0]               cnt;
  logic [7:0]               debounce;
  logic [PRESCALE_BITS-1:0] presc;
  logic                     ovf;

  logic       tick;
  logic       commit;
  logic       pop_req;
  logic       status_wr;
  logic       flush;
  logic       ovf_clr;
  logic       ovf_set;
  logic [7:0] fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic [3:0] fifo_count;
  logic [7:0] status;

  assign tick      = &presc;
  assign commit    = tick && (sync2 == cand) && (cnt == debounce) && (cand != craw);
  assign pop_req   = data_write && (address == ADDR_FIFO);
  assign status_wr = data_write && (address == ADDR_STATUS);
  assign flush     = status_wr && data_in[0];
  assign ovf_clr   = status_wr && data_in[7];
  // A flushed push is discarded rather than counted as an overflow.
  assign ovf_set   = commit && fifo_full && !pop_req && !flush;
  assign uo_out    = code;

  // Input synchroniser and free-running debounce prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 8'h00;
      sync2 <= 8'h00;
      presc <= '0;
    end else begin
      sync1 <= ui_in;
      sync2 <= sync1;
      presc <= presc + 1'b1;
    end
  end

  // Debounce: any change restarts the count; a pattern held DEBOUNCE ticks commits once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand <= 8'h00;
      craw <= 8'h00;
      code <= CODE_RESET;
      cnt  <= 8'h00;
    end else if (sync2 != cand) begin
      cand <= sync2;
      cnt  <= 8'h00;
    end else if (commit) begin
      craw <= cand;
      code <= encode_segments(cand[6:0], cand[7]);
      cnt  <= 8'h00;
    end else if (tick && (cnt < debounce)) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Writable registers: debounce threshold and sticky overflow (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      debounce <= DEBOUNCE_RESET;
      ovf      <= 1'b0;
    end else begin
      if (data_write && (address == ADDR_DEBOUNCE)) debounce <= data_in;
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  tqvp_rebeccargb_ubce_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (commit),
    .pop  (pop_req),
    .flush(flush),
    .din  (encode_segments(cand[6:0], cand[7])),
    .head (fifo_head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  // STATUS assembly and register read mux.
  always_comb begin
    status                   = 8'h00;
    status[STATUS_OVF_BIT]   = ovf;
    status[STATUS_EMPTY_BIT] = fifo_empty;
    status[STATUS_FULL_BIT]  = fifo_full;
    status[3:0]              = fifo_count;
    case (address)
      ADDR_CODE:     data_out = code;
      ADDR_FIFO:     data_out = fifo_head;
      ADDR_STATUS:   data_out = status;
      ADDR_DEBOUNCE: data_out = debounce;
      default:       data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_tqvp_rebeccargb_universal_encoder.sv
// Self-checking bench for the universal encoder with a behavioural reference model.
module tb_tqvp_rebeccargb_universal_encoder;

  localparam int P     = 2;
  localparam int DEPTH = 4;
  localparam logic [6:0] HEXPAT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out;
  logic [3:0] address = 4'h0;
  logic       data_write = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;

  int total = 0;
  int bad = 0;

  tqvp_rebeccargb_universal_encoder #(
    .PRESCALE_BITS(P),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ui_in     (ui_in),
    .uo_out    (uo_out),
    .address   (address),
    .data_write(data_write),
    .data_in   (data_in),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%02h required=%02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] q[$];
  logic [7:0] m_p1, m_p2, m_cand, m_craw, m_code, m_deb;
  int         m_cnt, m_edge;
  bit         m_ovf, m_commit_next;
  bit         m_tick, m_commit, m_pop_ok, m_oset, m_full_pre;
  logic [7:0] m_seen;

  function automatic logic [7:0] m_enc(input logic [7:0] raw);
    logic [6:0] s;
    logic [7:0] dpb;
    s   = raw[6:0];
    dpb = raw[7] ? 8'h10 : 8'h00;
    if (s == 7'h00) return 8'hC0 | dpb;
    if (s == 7'h40) return 8'hA0 | dpb;
    if (s == 7'h27) s = 7'h07;
    if (s == 7'h67) s = 7'h6F;
    for (int i = 0; i < 16; i++)
      if (HEXPAT[i] == s) return 8'h80 | dpb | 8'(i);
    return dpb;
  endfunction

  function automatic logic [7:0] m_read(input logic [3:0] a);
    case (a)
      4'h0: return m_code;
      4'h1: return (q.size() > 0) ? q[0] : 8'h00;
      4'h2: return {m_ovf, q.size() == 0, q.size() == DEPTH, 1'b0, 4'(q.size())};
      4'h3: return m_deb;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_p1 = 0; m_p2 = 0; m_cand = 0; m_craw = 0; m_code = 8'hC0; m_deb = 8'h0F;
      m_cnt = 0; m_edge = 0; m_ovf = 0; m_commit_next = 0;
    end else begin
      m_edge++;
      m_tick   = (m_edge % (1 << P)) == 0;
      m_seen   = m_p2;
      m_p2     = m_p1;
      m_p1     = ui_in;
      m_commit = 0;
      if (m_seen != m_cand) begin
        m_cand = m_seen;
        m_cnt  = 0;
      end else if (m_tick) begin
        if (m_cnt == int'(m_deb)) m_commit = (m_cand != m_craw);
        else if (m_cnt < int'(m_deb)) m_cnt++;
      end
      if (m_commit) begin
        m_craw = m_cand;
        m_code = m_enc(m_cand);
        m_cnt  = 0;
      end
      m_oset     = 0;
      m_full_pre = (q.size() == DEPTH);
      if (data_write && address == 4'h2 && data_in[0]) begin
        q.delete();
      end else begin
        m_pop_ok = data_write && address == 4'h1 && q.size() > 0;
        if (m_pop_ok) void'(q.pop_front());
        if (m_commit) begin
          if (!m_full_pre || m_pop_ok) q.push_back(m_code);
          else m_oset = 1;
        end
      end
      if (m_oset) m_ovf = 1;
      else if (data_write && address == 4'h2 && data_in[7]) m_ovf = 0;
      if (data_write && address == 4'h3) m_deb = data_in;
      m_commit_next = (m_p2 == m_cand) && (((m_edge + 1) % (1 << P)) == 0) &&
                      (m_cnt == int'(m_deb)) && (m_cand != m_craw);
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("cycle_uo_out", uo_out, m_code);
      chk("cycle_data_out", data_out, m_read(address));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    address = a; data_in = d; data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string name);
    address = a;
    #1;
    chk(name, data_out, exp);
  endtask

  task automatic wait_commit(input string name);
    int n;
    n = 0;
    while (!m_commit_next && n < 80) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!m_commit_next) begin
      bad++;
      $display("FAIL %s: no commit within %0d cycles, required one", name, n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    // Reset state
    #1; chk("reset_uo_out", uo_out, 8'hC0);
    rd(4'h2, 8'h40, "reset_status");
    rd(4'h3, 8'h0F, "reset_debounce");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    wr(4'h3, 8'h03);
    rd(4'h3, 8'h03, "debounce_write");
    wr(4'h0, 8'h55);
    rd(4'h0, 8'hC0, "code_readonly");
    rd(4'h9, 8'h00, "unmapped_read");
    idle(3);

    // Basic encode with latency window
    ui_in = 8'h5B;
    @(negedge clk);
    n = 0;
    while (uo_out !== 8'h82 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n < 14 || n > 18) begin
      bad++;
      $display("FAIL commit_latency: actual=%0d required=14..18", n);
    end
    idle(2);
    rd(4'h1, 8'h82, "basic_head");
    rd(4'h2, 8'h01, "basic_status");
    wr(4'h1, 8'h00);
    rd(4'h2, 8'h40, "basic_popped");

    // Bounce rejection
    for (int i = 0; i < 10; i++) begin
      ui_in = 8'h06; idle(5);
      ui_in = 8'h00; idle(5);
    end
    ui_in = 8'h06;
    idle(30);
    rd(4'h2, 8'h01, "bounce_count");
    rd(4'h1, 8'h81, "bounce_head");
    wr(4'h1, 8'h00);

    // Encodings
    ui_in = 8'h40; idle(25);
    ui_in = 8'hFF; idle(25);
    ui_in = 8'h27; idle(25);
    rd(4'h2, 8'h03, "enc_count");
    rd(4'h1, 8'hA0, "enc_minus"); wr(4'h1, 8'h00);
    rd(4'h1, 8'h98, "enc_eight_dp"); wr(4'h1, 8'h00);
    rd(4'h1, 8'h87, "enc_alt_seven"); wr(4'h1, 8'h00);
    ui_in = 8'h01; idle(25);
    rd(4'h0, 8'h00, "enc_unknown");
    rd(4'h2, 8'h01, "enc_unknown_count");
    wr(4'h1, 8'h00);

    // Overflow and STATUS writes
    ui_in = 8'h3F; idle(25);
    ui_in = 8'h06; idle(25);
    ui_in = 8'h5B; idle(25);
    ui_in = 8'h4F; idle(25);
    ui_in = 8'h66; idle(25);
    rd(4'h2, 8'hA4, "ovf_status");
    wr(4'h1, 8'h00);
    rd(4'h2, 8'h83, "ovf_after_pop");
    wr(4'h2, 8'h80);
    rd(4'h2, 8'h03, "ovf_cleared");
    wr(4'h2, 8'h01);
    rd(4'h2, 8'h40, "flushed");
    wr(4'h1, 8'h00);
    rd(4'h2, 8'h40, "pop_empty");
    rd(4'h0, 8'h84, "pop_empty_code");

    // Push coincident with pop at full
    ui_in = 8'h6D; idle(25);
    ui_in = 8'h7D; idle(25);
    ui_in = 8'h07; idle(25);
    ui_in = 8'h7F; idle(25);
    rd(4'h2, 8'h24, "full_status");
    ui_in = 8'h6F;
    wait_commit("wait_push_pop");
    wr(4'h1, 8'h00);
    rd(4'h2, 8'h24, "push_pop_full");
    rd(4'h1, 8'h86, "push_pop_head");

    // Flush coincident with push
    ui_in = 8'h77;
    wait_commit("wait_flush_push");
    wr(4'h2, 8'h01);
    rd(4'h2, 8'h40, "flush_push_status");
    rd(4'h0, 8'h8A, "flush_push_code");

    // Randomised traffic against the model
    for (int it = 0; it < 50; it++) begin
      case ($urandom_range(0, 3))
        0: ui_in = {1'($urandom_range(0, 1)), HEXPAT[$urandom_range(0, 15)]};
        1: ui_in = 8'($urandom);
        2: ui_in = $urandom_range(0, 1) ? 8'h40 : 8'h00;
        default: ui_in = $urandom_range(0, 1) ? 8'h27 : 8'hE7;
      endcase
      repeat ($urandom_range(1, 24)) begin
        address    = 4'($urandom_range(0, 15));
        data_write = ($urandom_range(0, 5) == 0);
        data_in    = (address == 4'h3) ? 8'($urandom_range(1, 4)) : 8'($urandom);
        @(negedge clk);
      end
      data_write = 1'b0;
    end
    idle(30);

    // Reset mid-cycle
    ui_in = 8'h4F;
    idle(3);
    #2 rst_n = 1'b0;
    #1 chk("midreset_uo_out", uo_out, 8'hC0);
    rd(4'h2, 8'h40, "midreset_status");
    rd(4'h3, 8'h0F, "midreset_debounce");
    @(negedge clk);
    rst_n = 1'b1;
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
